// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + cin over WIDTH/DIGIT cycles, DIGIT bits per cycle, LSB first.
// Define SERIAL_ADDER_OVF_EN to register the two's-complement overflow flag on ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      off_s;
  logic [DIGIT-1:0] dig_a_s, dig_b_s, dig_sum_s;
  logic             dig_cout_s;
  logic [WIDTH-1:0] work_next_s;
  logic             last_s;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  // Select the current digit of each operand and add it with the running carry
  always_comb begin
    off_s                    = 32'(cnt_q) * 32'(DIGIT);
    dig_a_s                  = DIGIT'(a_q >> off_s);
    dig_b_s                  = DIGIT'(b_q >> off_s);
    {dig_cout_s, dig_sum_s}  = digit_add(dig_a_s, dig_b_s, carry_q);
    // each digit slot is written exactly once per operation, so OR-ing into a cleared register is enough
    work_next_s              = work_q | (WIDTH'(dig_sum_s) << off_s);
    last_s                   = (cnt_q == CW'(N - 1));
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d, ovf_calc_s;

  // Same-sign operands producing an opposite-sign result is equivalent to carry-in(MSB) ^ carry-out(MSB)
  always_comb begin
    ovf_calc_s = (dig_a_s[DIGIT-1] == dig_b_s[DIGIT-1]) && (dig_sum_s[DIGIT-1] != dig_a_s[DIGIT-1]);
  end

  // Overflow flag register, updated only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // Overflow next value
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && last_s) begin
      ovf_d = ovf_calc_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = CW'(0);
          work_d  = {WIDTH{1'b0}};
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        work_d  = work_next_s;
        carry_d = dig_cout_s;
        cnt_d   = cnt_q + CW'(1);
        if (last_s) begin
          sum_d   = work_next_s;
          cout_d  = dig_cout_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand, working and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      work_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= CW'(0);
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (DIGIT = 1, 4, 8) against an arithmetic reference.
// Honours SERIAL_ADDER_OVF_EN the same way the design does.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic [7:0]  a = 8'h00, b = 8'h00;
  logic        cin = 1'b0;
  logic [2:0]  busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  sum_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer sum, signed overflow from the signed interpretation
  function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    int u, sx, sy, s;
    logic ov;
    u  = int'(x) + int'(y) + int'(c);
    sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
    s  = sx + sy + int'(c);
`ifdef SERIAL_ADDER_OVF_EN
    ov = (s > 127) || (s < -128);
`else
    ov = 1'b0;
`endif
    return {ov, u[8:0]};
  endfunction

  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int n, lat;
    logic [9:0] exp;
    logic [7:0] sum_before;
    bit held, busy_ok;
    n = (k == 0) ? 8 : (k == 1) ? 2 : 1;
    exp = ref_add(av, bv, cv);
    sum_before = sum_v[k];
    held = 1'b1;
    busy_ok = 1'b1;
    lat = 0;
    a = av; b = bv; cin = cv; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    check_eq($sformatf("busy_accept_d%0d", k), busy_v[k], 1'b1);
    for (int c = 1; c <= n + 3; c++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      start_v[k] = (c < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (done_v[k]) begin
        lat = c;
        break;
      end
      if (sum_v[k] !== sum_before) held = 1'b0;
      if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
    end
    start_v[k] = 1'b0;
    check_eq($sformatf("latency_d%0d", k), lat, n);
    check_eq($sformatf("sum_held_d%0d", k), held, 1'b1);
    check_eq($sformatf("busy_run_d%0d", k), busy_ok, 1'b1);
    check_eq($sformatf("sum_d%0d", k), sum_v[k], exp[7:0]);
    check_eq($sformatf("cout_d%0d", k), cout_v[k], exp[8]);
    check_eq($sformatf("ovf_d%0d", k), ovf_v[k], exp[9]);
    check_eq($sformatf("busy_done_d%0d", k), busy_v[k], 1'b0);
    @(posedge clk); #1;
    check_eq($sformatf("done_pulse_d%0d", k), done_v[k], 1'b0);
    check_eq($sformatf("sum_keep_d%0d", k), sum_v[k], exp[7:0]);
  endtask

  initial begin
    logic [9:0] expq[$];
    logic [9:0] e;
    logic [7:0] prev_sum;
    bit prev_done, stable, saw_done;
    int last_done, ndone;

    #12;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_busy_d%0d", k), busy_v[k], 1'b0);
      check_eq($sformatf("rst_done_d%0d", k), done_v[k], 1'b0);
      check_eq($sformatf("rst_sum_d%0d", k), sum_v[k], 8'h00);
      check_eq($sformatf("rst_cout_d%0d", k), {cout_v[k], ovf_v[k]}, 2'b00);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 8'h5A, 8'h3C, 1'b0);
    run_op(0, 8'hFF, 8'h01, 1'b0);
    run_op(0, 8'hFF, 8'hFF, 1'b1);
    run_op(0, 8'h7F, 8'h01, 1'b0);
    run_op(0, 8'h80, 8'h80, 1'b0);
    run_op(1, 8'h99, 8'h88, 1'b0);
    run_op(2, 8'h99, 8'h88, 1'b0);
    run_op(1, 8'h7F, 8'h01, 1'b0);
    run_op(2, 8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 12; i++) begin
      run_op(i % 3, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Back-to-back with start held high on the DIGIT=1 instance
    prev_done = 1'b1;
    stable = 1'b1;
    last_done = -1;
    ndone = 0;
    prev_sum = sum_v[0];
    for (int c = 0; c < 75; c++) begin
      start_v[0] = (c < 55);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      if (prev_done && start_v[0]) expq.push_back(ref_add(a, b, cin));
      @(posedge clk); #1;
      prev_done = done_v[0];
      if (done_v[0]) begin
        ndone++;
        if (last_done >= 0) check_eq("b2b_interval", c - last_done, 9);
        last_done = c;
        e = (expq.size() > 0) ? expq.pop_front() : 10'h3FF;
        check_eq("b2b_result", {ovf_v[0], cout_v[0], sum_v[0]}, e);
        prev_sum = sum_v[0];
      end else if (sum_v[0] !== prev_sum) begin
        stable = 1'b0;
      end
    end
    start_v[0] = 1'b0;
    check_eq("b2b_count", ndone, 7);
    check_eq("b2b_pending", expq.size(), 0);
    check_eq("b2b_stable", stable, 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of an operation
    run_op(0, 8'h12, 8'h34, 1'b0);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy_v[0], 1'b0);
    check_eq("arst_sum", sum_v[0], 8'h00);
    check_eq("arst_flags", {done_v[0], cout_v[0], ovf_v[0]}, 3'b000);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_v[0]) saw_done = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) saw_done = 1'b1;
    end
    check_eq("arst_no_done", saw_done, 1'b0);
    check_eq("arst_sum_after", sum_v[0], 8'h00);
    run_op(0, 8'hC3, 8'h5A, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder. It computes a + b + cin over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle LSB-first through a registered carry. It is the sequential successor to the single-bit half/full adder lab blocks and is intended as the arithmetic datapath element for later lab ALU/accumulator work. A start/busy/done handshake allows back-to-back operations.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
DIGIT, 1, bits added per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT is the cycle count.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when the block is not busy
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; sum/cout/ovf are valid from this cycle
sum  output  WIDTH  result; held stable until the next completion
cout  output  1  carry-out of the MSB; held like sum
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and digit counter cleared. This also applies mid-operation: the partial result is discarded and done is never pulsed for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge E0: latch a, b, cin (cin seeds the carry register); counter=0; go to RUN; busy=1 from E0.
- IDLE or DONE with start=0: go to or stay in IDLE; done=0.
- RUN, edge Ei (i=1..N): add digit i-1 (bits [i*DIGIT-1:(i-1)*DIGIT]) plus carry.
  - Store the DIGIT-bit result into the working register.
  - Update the carry register.
  - Increment the counter.
- RUN at edge EN (last digit): go to DONE.
  - Load the working result into sum and the final carry into cout; update ovf.
  - busy=0 and done=1 for exactly the following cycle.
- Latency: exactly N cycles from the accepting edge to done high. Throughput is one result per N+1 cycles with back-to-back start, since start is accepted in DONE.
- start while in RUN is ignored; operands are not re-captured, and a/b/cin may change freely during RUN.
- sum/cout/ovf change only on a completion edge or reset and never show partial results.
- Arithmetic is unsigned modulo 2^WIDTH: {cout, sum} = a + b + cin, (WIDTH+1)-bit exact.
- DIGIT=WIDTH is legal: N=1, one RUN cycle.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: on the completion edge, ovf = carry into MSB XOR carry out of MSB (two's-complement overflow); held like sum; cleared by reset.
- Undefined: ovf is tied to constant 0, and no extra logic is generated.
- The port exists in both builds.

Test Plan:
1. WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, cin=0, start pulse → done exactly 8 cycles after the accepting edge; sum=0x96, cout=0; busy high for those 8 cycles.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
3. start held high continuously with changing operands → results complete every 9 cycles; start pulses and operand changes during RUN do not alter the in-flight result; sum stays stable between done pulses.
4. rst_n driven low at cycle 4 of an operation → all outputs 0 immediately (async), no done pulse; the next start after release gives a correct result.
5. WIDTH=8, DIGIT=4: a=0x99, b=0x88 → done after 2 cycles, sum=0x21, cout=1. Also DIGIT=8 → done after 1 cycle.
6. With SERIAL_ADDER_OVF_EN defined: a=0x7F, b=0x01 → sum=0x80, ovf=1; a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1. With the macro undefined: ovf=0 for both.
